// File: rtl/task_1_pkg.sv
// Shared types and constants for the multi-channel debouncer.
package task_1_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int ANSWER_W       = 32;
   localparam int SIZE_W         = 12;

   typedef enum logic [1:0] {
      MODE_PASS = 2'd0,
      MODE_DEB  = 2'd1,
      MODE_RISE = 2'd2
   } mode_e;

   typedef enum logic {
      RECV  = 1'b0,
      DRAIN = 1'b1
   } state_e;

   // One answer-FIFO entry.
   typedef struct packed {
      logic                last;
      logic [ANSWER_W-1:0] data;
   } ans_t;

   // Encoding 3 is an alias of debounce.
   function automatic mode_e decode_mode(input logic [1:0] m);
      mode_e r;
      case (m)
         2'd0:    r = MODE_PASS;
         2'd2:    r = MODE_RISE;
         default: r = MODE_DEB;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/task_1_dbnc_ch.sv
// Single-channel debouncer: stable state plus run-length counter of differing samples.
module task_1_dbnc_ch
   import task_1_pkg::*;
#(
   parameter int STABLE_CNT = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   input  logic i_x,
   output logic o_s_nxt,
   output logic o_rise
);

   logic       s_q, s_d;
   logic [7:0] c_q, c_d;
   logic [8:0] c_inc;

   assign c_inc = {1'b0, c_q} + 9'd1;

   // Next state/counter for the current sample; packet end wipes the history.
   always_comb begin
      s_d = s_q;
      c_d = c_q;
      if (i_en) begin
         if (i_x == s_q) begin
            c_d = '0;
         end else if (c_inc == 9'(STABLE_CNT)) begin
            s_d = i_x;
            c_d = '0;
         end else begin
            c_d = c_inc[7:0];
         end
      end
      if (i_clr) begin
         s_d = 1'b0;
         c_d = '0;
      end
   end

   // State registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s_q <= 1'b0;
         c_q <= '0;
      end else begin
         s_q <= s_d;
         c_q <= c_d;
      end
   end

   // Same-cycle result: the byte's own update is visible immediately.
   assign o_s_nxt = s_d;
   assign o_rise  = s_d & ~s_q;

endmodule

// File: rtl/task_1_mch_debounce.sv
// Streaming multi-channel debouncer: bytes in, packed 32-bit answer words out via a small FIFO.
module task_1_mch_debounce
   import task_1_pkg::*;
#(
   parameter int NUM_CH     = 8,
   parameter int STABLE_CNT = 4,
   parameter int MAX_BYTES  = 100,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [1:0]          i_mode,
   input  logic                i_tdata_valid,
   input  logic [7:0]          i_tdata,
   input  logic                i_tdata_last,
   output logic                o_tready,
   input  logic                i_tmanager_ready,
   output logic                o_tanswer_ready,
   output logic [ANSWER_W-1:0] o_tanswer_data,
   output logic                o_tanswer_data_last,
   output logic [SIZE_W-1:0]   o_packet_size_in_bytes
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   state_e              state_q, state_d;
   mode_e               mode_q, mode_d, mode_cur;
   logic                first_q, first_d;
   logic [SIZE_W-1:0]   cnt_q, cnt_d;
   logic [SIZE_W-1:0]   size_q, size_d;
   logic [ANSWER_W-1:0] pack_q, pack_d;

   ans_t                mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0]    fcnt_q, fcnt_d;
   ans_t                head;

   logic                full, empty, accept, pop, store, drain_done;
   logic                push;
   ans_t                push_ent;
   logic [ANSWER_W-1:0] word_w;
   logic [7:0]          s_nxt, rise, res_byte;

   assign full       = (fcnt_q == CNT_W'(FIFO_DEPTH));
   assign empty      = (fcnt_q == '0);
   assign head       = mem_q[rd_q];
   assign o_tready   = (state_q == RECV) && !full;
   assign accept     = i_tdata_valid && o_tready;
   assign pop        = !empty && i_tmanager_ready;
   assign store      = accept && (cnt_q < SIZE_W'(MAX_BYTES));
   assign drain_done = (state_q == DRAIN) && pop && head.last;

   // The first byte of a packet samples i_mode directly so it sees the new mode.
   assign mode_cur = first_q ? decode_mode(i_mode) : mode_q;

   for (genvar g = 0; g < 8; g++) begin : g_ch
      if (g < NUM_CH) begin : g_on
         task_1_dbnc_ch #(.STABLE_CNT(STABLE_CNT)) u_ch (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_en    (accept),
            .i_clr   (drain_done),
            .i_x     (i_tdata[g]),
            .o_s_nxt (s_nxt[g]),
            .o_rise  (rise[g])
         );
      end else begin : g_off
         assign s_nxt[g] = 1'b0;
         assign rise[g]  = 1'b0;
      end
   end

   // Per-channel result bit selected by the packet's mode; unused channels stay 0.
   always_comb begin
      res_byte = '0;
      for (int b = 0; b < NUM_CH; b++) begin
         case (mode_cur)
            MODE_PASS: res_byte[b] = i_tdata[b];
            MODE_RISE: res_byte[b] = rise[b];
            default:   res_byte[b] = s_nxt[b];
         endcase
      end
   end

   // Packing, byte counting and RECV/DRAIN sequencing.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      first_d  = first_q;
      cnt_d    = cnt_q;
      size_d   = size_q;
      pack_d   = pack_q;
      push     = 1'b0;
      push_ent = '0;
      word_w   = pack_q;
      if (store) word_w[{cnt_q[1:0], 3'b000} +: 8] = res_byte;
      if (accept) begin
         first_d = 1'b0;
         if (first_q) mode_d = mode_cur;
         if (store) begin
            cnt_d  = cnt_q + 12'd1;
            size_d = cnt_q + 12'd1;
            pack_d = word_w;
         end
         if (i_tdata_last) begin
            // Partial (or empty, if everything was already flushed) pack closes the packet.
            push          = 1'b1;
            push_ent.data = word_w;
            push_ent.last = 1'b1;
            pack_d        = '0;
            state_d       = DRAIN;
         end else if (store && (cnt_q[1:0] == 2'd3)) begin
            push          = 1'b1;
            push_ent.data = word_w;
            pack_d        = '0;
         end
      end
      if (drain_done) begin
         // Size output deliberately keeps its value until the next packet's first byte.
         state_d = RECV;
         cnt_d   = '0;
         pack_d  = '0;
         first_d = 1'b1;
      end
   end

   // FIFO pointer/occupancy next values.
   always_comb begin
      wr_d   = push ? wr_q + 1'b1 : wr_q;
      rd_d   = pop  ? rd_q + 1'b1 : rd_q;
      fcnt_d = fcnt_q;
      case ({push, pop})
         2'b10:   fcnt_d = fcnt_q + 1'b1;
         2'b01:   fcnt_d = fcnt_q - 1'b1;
         default: fcnt_d = fcnt_q;
      endcase
   end

   // Control and datapath registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= RECV;
         mode_q  <= MODE_PASS;
         first_q <= 1'b1;
         cnt_q   <= '0;
         size_q  <= '0;
         pack_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         first_q <= first_d;
         cnt_q   <= cnt_d;
         size_q  <= size_d;
         pack_q  <= pack_d;
      end
   end

   // Answer FIFO storage; the head entry drives the outputs straight from flops.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         fcnt_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         fcnt_q <= fcnt_d;
         if (push) mem_q[wr_q] <= push_ent;
      end
   end

   assign o_tanswer_ready        = !empty;
   assign o_tanswer_data         = head.data;
   assign o_tanswer_data_last    = head.last;
   assign o_packet_size_in_bytes = size_q;

endmodule

// File: tb/tb_task_1_mch_debounce.sv
// Directed bench: two instances (8ch/STABLE 4 and 4ch/STABLE 2) share one stimulus stream.
module tb_task_1_mch_debounce;

   logic        clk = 1'b0;
   logic        rst, valid, last, mgr;
   logic [1:0]  mode;
   logic [7:0]  data;

   logic        a_tready, a_rdy, a_last, b_tready, b_rdy, b_last;
   logic [31:0] a_data, b_data;
   logic [11:0] a_size, b_size;

   logic [31:0] qa_w[$], qb_w[$];
   logic        qa_l[$], qb_l[$];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   task_1_mch_debounce #(.NUM_CH(8), .STABLE_CNT(4), .MAX_BYTES(100), .FIFO_DEPTH(4)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_tdata_valid(valid), .i_tdata(data),
      .i_tdata_last(last), .o_tready(a_tready), .i_tmanager_ready(mgr),
      .o_tanswer_ready(a_rdy), .o_tanswer_data(a_data), .o_tanswer_data_last(a_last),
      .o_packet_size_in_bytes(a_size));

   task_1_mch_debounce #(.NUM_CH(4), .STABLE_CNT(2), .MAX_BYTES(100), .FIFO_DEPTH(4)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_tdata_valid(valid), .i_tdata(data),
      .i_tdata_last(last), .o_tready(b_tready), .i_tmanager_ready(mgr),
      .o_tanswer_ready(b_rdy), .o_tanswer_data(b_data), .o_tanswer_data_last(b_last),
      .o_packet_size_in_bytes(b_size));

   // Record every answer word that will transfer on the coming rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (a_rdy && mgr) begin qa_w.push_back(a_data); qa_l.push_back(a_last); end
         if (b_rdy && mgr) begin qb_w.push_back(b_data); qb_l.push_back(b_last); end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic clr_q();
      qa_w.delete(); qa_l.delete(); qb_w.delete(); qb_l.delete();
   endtask

   // Called at posedge+1; holds the byte until accepted, returns at posedge+1.
   task automatic send(input logic [7:0] b, input logic l);
      int guard = 0;
      valid = 1'b1; data = b; last = l;
      while (!a_tready && guard < 300) begin
         @(posedge clk); #1; guard++;
      end
      if (guard >= 300) chk("tready_wait", {31'd0, a_tready}, 32'd1);
      @(posedge clk); #1;
      valid = 1'b0; last = 1'b0; data = 8'h00;
   endtask

   task automatic wait_last();
      int guard = 0;
      while (!(qa_l.size() > 0 && qa_l[qa_l.size()-1]) && guard < 500) begin
         @(negedge clk); guard++;
      end
      chk("last_seen", {31'd0, (qa_l.size() > 0) ? qa_l[qa_l.size()-1] : 1'b0}, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] exp_w;
      logic [7:0]  bb;
      rst = 1'b1; valid = 1'b0; last = 1'b0; mgr = 1'b0; mode = 2'd0; data = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_tready", {31'd0, a_tready}, 32'd1);
      chk("rst_ans_rdy", {31'd0, a_rdy}, 32'd0);
      chk("rst_data", a_data, 32'd0);
      chk("rst_last", {31'd0, a_last}, 32'd0);
      chk("rst_size", {20'd0, a_size}, 32'd0);
      @(posedge clk); #1;

      // Test 1: debounce, STABLE 4, ch0 bouncing
      clr_q(); mgr = 1'b1; mode = 2'd1;
      send(8'h00, 0); send(8'h01, 0); send(8'h01, 0); send(8'h01, 0);
      send(8'h01, 0); send(8'h00, 0); send(8'h01, 1);
      wait_last();
      chk("t1_nwords", qa_w.size(), 32'd2);
      chk("t1_w0", qa_w[0], 32'h0000_0000);
      chk("t1_l0", {31'd0, qa_l[0]}, 32'd0);
      chk("t1_w1", qa_w[1], 32'h0001_0101);
      chk("t1_size", {20'd0, a_size}, 32'd7);

      // Size holds after drain until the next packet starts
      repeat (3) @(posedge clk); #1;
      chk("t1_size_hold", {20'd0, a_size}, 32'd7);

      // Test 2: pass-through
      clr_q(); mode = 2'd0;
      send(8'hA5, 0); send(8'h3C, 0); send(8'hFF, 1);
      wait_last();
      chk("t2_nwords", qa_w.size(), 32'd1);
      chk("t2_w0", qa_w[0], 32'h00FF_3CA5);
      chk("t2_size", {20'd0, a_size}, 32'd3);

      // Test 3: rise-edge; upper nibble ignored by the 4-channel instance
      clr_q(); mode = 2'd2;
      send(8'hF0, 0); send(8'hF8, 0); send(8'hF8, 0);
      send(8'hF8, 0); send(8'hF0, 0); send(8'hF0, 1);
      wait_last();
      chk("t3_b_nwords", qb_w.size(), 32'd2);
      chk("t3_b_w0", qb_w[0], 32'h0008_0000);
      chk("t3_b_w1", qb_w[1], 32'h0000_0000);
      chk("t3_b_l1", {31'd0, qb_l[1]}, 32'd1);
      chk("t3_a_w0", qa_w[0], 32'hF000_0000);
      chk("t3_a_w1", qa_w[1], 32'h0000_0000);
      chk("t3_b_size", {20'd0, b_size}, 32'd6);

      // Test 4: 105 bytes, only 100 stored
      clr_q(); mode = 2'd0;
      for (int i = 0; i < 105; i++) send(8'(i + 1), (i == 104));
      wait_last();
      chk("t4_nwords", qa_w.size(), 32'd26);
      for (int k = 0; k < 25; k++) begin
         exp_w = '0;
         for (int j = 0; j < 4; j++) begin
            bb = 8'(4 * k + j + 1);
            exp_w[8*j +: 8] = bb;
         end
         chk($sformatf("t4_w%0d", k), qa_w[k], exp_w);
         chk($sformatf("t4_l%0d", k), {31'd0, qa_l[k]}, 32'd0);
      end
      chk("t4_w25", qa_w[25], 32'd0);
      chk("t4_size", {20'd0, a_size}, 32'd100);

      // Test 5: back-pressure with the manager stalled
      clr_q(); mgr = 1'b0; mode = 2'd0;
      for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 0);
      @(negedge clk);
      chk("t5_tready_full", {31'd0, a_tready}, 32'd0);
      chk("t5_ans_rdy", {31'd0, a_rdy}, 32'd1);
      chk("t5_head", a_data, 32'h1312_1110);
      @(posedge clk); #1 mgr = 1'b1;
      @(posedge clk); #1 mgr = 1'b0;
      chk("t5_tready_resume", {31'd0, a_tready}, 32'd1);
      mgr = 1'b1;
      for (int i = 16; i < 20; i++) send(8'(8'h10 + i), (i == 19));
      wait_last();
      chk("t5_nwords", qa_w.size(), 32'd5);
      for (int k = 0; k < 5; k++) begin
         exp_w = '0;
         for (int j = 0; j < 4; j++) begin
            bb = 8'(8'h10 + 4 * k + j);
            exp_w[8*j +: 8] = bb;
         end
         chk($sformatf("t5_w%0d", k), qa_w[k], exp_w);
      end
      chk("t5_size", {20'd0, a_size}, 32'd20);

      // Test 6: reset mid-packet, then debounce restarts from state 0
      clr_q(); mgr = 1'b0; mode = 2'd1;
      for (int i = 0; i < 6; i++) send(8'h01, 0);
      @(negedge clk);
      chk("t6_pre_ans_rdy", {31'd0, a_rdy}, 32'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("t6_ans_rdy", {31'd0, a_rdy}, 32'd0);
      chk("t6_size", {20'd0, a_size}, 32'd0);
      chk("t6_tready", {31'd0, a_tready}, 32'd1);
      clr_q(); mgr = 1'b1;
      send(8'h01, 0); send(8'h01, 1);
      wait_last();
      chk("t6_nwords", qa_w.size(), 32'd1);
      chk("t6_w0", qa_w[0], 32'h0000_0000);
      chk("t6_size2", {20'd0, a_size}, 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
